// File: rtl/gpio_axi_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : gpio_axi_multi_if
// Description : AXI4-Lite channel bundle between the bus master and the GPIO.
// Revision    : 1.0 - initial release
// ============================================================================
interface gpio_axi_multi_if;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic        axi_wvalid;
    logic        axi_wready;
    logic        b_valid;
    logic        b_ready;
    logic [1:0]  b_response;

    modport master (
        output axi_araddr, axi_arvalid, axi_rready,
        output axi_awaddr, axi_awvalid, axi_wdata, axi_wvalid, b_ready,
        input  axi_arready, axi_rdata, axi_rresp, axi_rvalid,
        input  axi_awready, axi_wready, b_valid, b_response
    );

    modport slave (
        input  axi_araddr, axi_arvalid, axi_rready,
        input  axi_awaddr, axi_awvalid, axi_wdata, axi_wvalid, b_ready,
        output axi_arready, axi_rdata, axi_rresp, axi_rvalid,
        output axi_awready, axi_wready, b_valid, b_response
    );
endinterface
`default_nettype wire

// File: rtl/gpio_axi_multi.sv
`default_nettype none
// ============================================================================
// Module      : gpio_axi_multi
// Description : AXI4-Lite GPIO with synchronised inputs, set/clear outputs and
//               per-bit edge interrupts combined onto one level irq line.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_axi_multi #(
    parameter int                   IN_WIDTH  = 4,
    parameter int                   OUT_WIDTH = 8,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET = '0
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    gpio_axi_multi_if.slave           bus,
    input  wire logic [IN_WIDTH-1:0]  sw,
    output logic      [OUT_WIDTH-1:0] led,
    output logic                      irq
);

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    localparam logic [2:0] c_REG_IN     = 3'd0;
    localparam logic [2:0] c_REG_OUT    = 3'd1;
    localparam logic [2:0] c_REG_SET    = 3'd2;
    localparam logic [2:0] c_REG_CLR    = 3'd3;
    localparam logic [2:0] c_REG_EN     = 3'd4;
    localparam logic [2:0] c_REG_STATUS = 3'd5;
    localparam logic [2:0] c_REG_EDGE   = 3'd6;
    localparam logic [2:0] c_REG_NONE   = 3'd7;

    localparam int c_DW = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;

    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;
    typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;

    rd_state_t             r_rd_state, w_rd_next;
    wr_state_t             r_wr_state, w_wr_next;

    logic                  r_live;
    logic [IN_WIDTH-1:0]   r_sync_meta, r_sync, r_prev;
    logic [IN_WIDTH-1:0]   r_irq_en, r_irq_status, r_irq_edge;
    logic [OUT_WIDTH-1:0]  r_led;
    logic                  r_irq;
    logic [31:0]           r_rdata;
    logic [1:0]            r_rresp;
    logic                  r_aw_held, r_w_held;
    logic [2:0]            r_aw_idx;
    logic [c_DW-1:0]       r_wdata;
    logic [1:0]            r_bresp;

    logic                  w_arready, w_rvalid;
    logic                  w_awready, w_wready, w_bvalid, w_do_write;
    logic [31:0]           w_rd_data;
    logic [1:0]            w_rd_resp;
    logic [IN_WIDTH-1:0]   w_edge, w_status_clr;
    logic                  w_unused;

    // Readies stay low until the first edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_live <= 1'b0;
        else        r_live <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Input synchroniser and edge detection
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_meta <= '0;
            r_sync      <= '0;
            r_prev      <= '0;
        end else begin
            r_sync_meta <= sw;
            r_sync      <= r_sync_meta;
            r_prev      <= r_sync;
        end
    end

    assign w_edge = (r_irq_edge & r_sync & ~r_prev) | (~r_irq_edge & ~r_sync & r_prev);

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rd_state <= R_IDLE;
        else        r_rd_state <= w_rd_next;
    end

    always_comb begin
        w_rd_next = r_rd_state;
        w_arready = 1'b0;
        w_rvalid  = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                w_arready = r_live;
                if (r_live && bus.axi_arvalid) w_rd_next = R_DATA;
            end
            R_DATA: begin
                w_rvalid = 1'b1;
                if (bus.axi_rready) w_rd_next = R_IDLE;
            end
            default: w_rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_rd_data = 32'd0;
        w_rd_resp = c_RESP_OKAY;
        case (bus.axi_araddr[4:2])
            c_REG_IN:     w_rd_data[IN_WIDTH-1:0]  = r_sync;
            c_REG_OUT:    w_rd_data[OUT_WIDTH-1:0] = r_led;
            c_REG_EN:     w_rd_data[IN_WIDTH-1:0]  = r_irq_en;
            c_REG_STATUS: w_rd_data[IN_WIDTH-1:0]  = r_irq_status;
            c_REG_EDGE:   w_rd_data[IN_WIDTH-1:0]  = r_irq_edge;
            c_REG_NONE:   w_rd_resp = c_RESP_SLVERR;
            default:      w_rd_data = 32'd0;
        endcase
    end

    // Data is sampled at the address handshake, so a same-cycle write is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 32'd0;
            r_rresp <= c_RESP_OKAY;
        end else if (w_arready && bus.axi_arvalid) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_resp;
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_wr_state <= W_IDLE;
        else        r_wr_state <= w_wr_next;
    end

    always_comb begin
        w_wr_next  = r_wr_state;
        w_awready  = 1'b0;
        w_wready   = 1'b0;
        w_bvalid   = 1'b0;
        w_do_write = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                w_awready = r_live && !r_aw_held;
                w_wready  = r_live && !r_w_held;
                if (r_aw_held && r_w_held) begin
                    w_do_write = 1'b1;
                    w_wr_next  = W_RESP;
                end
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (bus.b_ready) w_wr_next = W_IDLE;
            end
            default: w_wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= 3'd0;
            r_wdata   <= '0;
            r_bresp   <= c_RESP_OKAY;
        end else if (w_do_write) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bresp   <= (r_aw_idx == c_REG_IN || r_aw_idx == c_REG_NONE) ?
                         c_RESP_SLVERR : c_RESP_OKAY;
        end else begin
            if (w_awready && bus.axi_awvalid) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= bus.axi_awaddr[4:2];
            end
            if (w_wready && bus.axi_wvalid) begin
                r_w_held <= 1'b1;
                r_wdata  <= bus.axi_wdata[c_DW-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led      <= OUT_RESET;
            r_irq_en   <= '0;
            r_irq_edge <= '0;
        end else if (w_do_write) begin
            case (r_aw_idx)
                c_REG_OUT:  r_led      <= r_wdata[OUT_WIDTH-1:0];
                c_REG_SET:  r_led      <= r_led | r_wdata[OUT_WIDTH-1:0];
                c_REG_CLR:  r_led      <= r_led & ~r_wdata[OUT_WIDTH-1:0];
                c_REG_EN:   r_irq_en   <= r_wdata[IN_WIDTH-1:0];
                c_REG_EDGE: r_irq_edge <= r_wdata[IN_WIDTH-1:0];
                default:    r_led      <= r_led;
            endcase
        end
    end

    assign w_status_clr = (w_do_write && r_aw_idx == c_REG_STATUS) ?
                          r_wdata[IN_WIDTH-1:0] : '0;

    // A new edge in the same cycle as a write-one-to-clear keeps the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_status <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_irq_status <= (r_irq_status & ~w_status_clr) | w_edge;
            r_irq        <= |(r_irq_status & r_irq_en);
        end
    end

    assign bus.axi_arready = w_arready;
    assign bus.axi_rvalid  = w_rvalid;
    assign bus.axi_rdata   = r_rdata;
    assign bus.axi_rresp   = r_rresp;
    assign bus.axi_awready = w_awready;
    assign bus.axi_wready  = w_wready;
    assign bus.b_valid     = w_bvalid;
    assign bus.b_response  = r_bresp;
    assign led             = r_led;
    assign irq             = r_irq;

    // Address bits outside [4:2] and data bits above the widest register alias away.
    assign w_unused = ^{bus.axi_araddr[31:5], bus.axi_araddr[1:0],
                        bus.axi_awaddr[31:5], bus.axi_awaddr[1:0], bus.axi_wdata};

endmodule
`default_nettype wire

// File: tb/tb_gpio_axi_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_axi_multi
// Description : Scoreboard bench for gpio_axi_multi (IN_WIDTH=4, OUT_WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_axi_multi;

    localparam int         IN_WIDTH  = 4;
    localparam int         OUT_WIDTH = 8;
    localparam logic [7:0] OUT_RESET = 8'h3C;
    localparam logic [1:0] OKAY      = 2'b00;
    localparam logic [1:0] SLVERR    = 2'b10;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    logic                 clk;
    logic                 rst_n;
    logic [IN_WIDTH-1:0]  sw;
    logic [OUT_WIDTH-1:0] led;
    logic                 irq;

    int n_compared   = 0;
    int n_mismatched = 0;

    rd_exp_t      rd_q[$];
    logic [1:0]   wr_q[$];

    gpio_axi_multi_if bus ();

    gpio_axi_multi #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .OUT_RESET (OUT_RESET)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .sw    (sw),
        .led   (led),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input int hold);
        rd_exp_t e;
        int      cnt;
        cnt    = 0;
        e.data = exp_data;
        e.resp = exp_resp;
        rd_q.push_back(e);
        bus.axi_araddr  = addr;
        bus.axi_arvalid = 1'b1;
        while (!bus.axi_arready && cnt < 20) begin
            tick(1);
            cnt++;
        end
        check_value("ar_wait", 32'(cnt < 20), 32'd1);
        tick(1);
        bus.axi_arvalid = 1'b0;
        check_value("rvalid_latency", 32'(bus.axi_rvalid), 32'd1);
        for (int k = 0; k < hold; k++) begin
            check_value("rdata_hold", bus.axi_rdata, rd_q[0].data);
            tick(1);
            check_value("rvalid_hold", 32'(bus.axi_rvalid), 32'd1);
        end
        e = rd_q.pop_front();
        check_value("rdata", bus.axi_rdata, e.data);
        check_value("rresp", 32'(bus.axi_rresp), 32'(e.resp));
        bus.axi_rready = 1'b1;
        tick(1);
        bus.axi_rready = 1'b0;
        check_value("rvalid_drop", 32'(bus.axi_rvalid), 32'd0);
        check_value("arready_back", 32'(bus.axi_arready), 32'd1);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] exp_resp, input int lead,
                             input logic hold_resp, input logic [7:0] led_hold);
        logic       aw_todo, w_todo, hs_aw, hs_w;
        logic [1:0] e;
        int         cyc, cnt;
        aw_todo = 1'b1;
        w_todo  = 1'b1;
        cyc     = 0;
        cnt     = 0;
        wr_q.push_back(exp_resp);
        bus.axi_awaddr  = addr;
        bus.axi_wdata   = data;
        bus.axi_wvalid  = 1'b1;
        bus.axi_awvalid = (lead == 0);
        while ((aw_todo || w_todo) && cyc < 40) begin
            hs_aw = bus.axi_awvalid && bus.axi_awready;
            hs_w  = bus.axi_wvalid && bus.axi_wready;
            tick(1);
            cyc++;
            if (hs_aw) begin bus.axi_awvalid = 1'b0; aw_todo = 1'b0; end
            if (hs_w)  begin bus.axi_wvalid  = 1'b0; w_todo  = 1'b0; end
            if (lead > 0 && aw_todo) begin
                check_value("wready_after_w", 32'(bus.axi_wready), 32'd0);
                check_value("led_before_aw", 32'(led), 32'(led_hold));
            end
            if (aw_todo && cyc >= lead) bus.axi_awvalid = 1'b1;
        end
        check_value("wr_hs_wait", 32'(cyc < 40), 32'd1);
        while (!bus.b_valid && cnt < 10) begin
            tick(1);
            cnt++;
        end
        check_value("b_latency", 32'(cnt), 32'd1);
        e = wr_q.pop_front();
        check_value("b_response", 32'(bus.b_response), 32'(e));
        if (!hold_resp) begin
            bus.b_ready = 1'b1;
            tick(1);
            bus.b_ready = 1'b0;
            check_value("b_single", 32'(bus.b_valid), 32'd0);
            check_value("readies_back", 32'({bus.axi_awready, bus.axi_wready}), 32'd3);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        sw              = 4'b1010;
        bus.axi_araddr  = '0;
        bus.axi_arvalid = 1'b0;
        bus.axi_rready  = 1'b0;
        bus.axi_awaddr  = '0;
        bus.axi_awvalid = 1'b0;
        bus.axi_wdata   = '0;
        bus.axi_wvalid  = 1'b0;
        bus.b_ready     = 1'b0;

        tick(2);
        check_value("rst_readies", 32'({bus.axi_arready, bus.axi_awready, bus.axi_wready}), 32'd0);
        check_value("rst_valids", 32'({bus.axi_rvalid, bus.b_valid, irq}), 32'd0);
        check_value("rst_led", 32'(led), 32'(OUT_RESET));
        #2 rst_n = 1'b1;
        tick(1);
        check_value("readies_up", 32'({bus.axi_arready, bus.axi_awready, bus.axi_wready}), 32'd7);
        tick(2);

        axi_read(32'h00, 32'h0000000A, OKAY, 0);

        axi_write(32'h04, 32'hFFFFFF5A, OKAY, 0, 1'b0, 8'h00);
        check_value("led_out", 32'(led), 32'h5A);
        axi_write(32'h08, 32'h81, OKAY, 0, 1'b0, 8'h00);
        check_value("led_set", 32'(led), 32'hDB);
        axi_read(32'h08, 32'h0, OKAY, 0);
        axi_read(32'h24, 32'hDB, OKAY, 0);
        axi_write(32'h0C, 32'h0F, OKAY, 0, 1'b0, 8'h00);
        check_value("led_clr", 32'(led), 32'hD0);

        axi_write(32'h04, 32'h33, OKAY, 3, 1'b0, 8'hD0);
        check_value("led_w_first", 32'(led), 32'h33);

        axi_read(32'h14, 32'h0, OKAY, 0);
        axi_write(32'h10, 32'h1, OKAY, 0, 1'b0, 8'h00);
        axi_write(32'h18, 32'h1, OKAY, 0, 1'b0, 8'h00);
        sw = 4'b1011;
        tick(3);
        check_value("irq_early", 32'(irq), 32'd0);
        tick(1);
        check_value("irq_set", 32'(irq), 32'd1);
        axi_read(32'h14, 32'h1, OKAY, 0);
        axi_write(32'h14, 32'h1, OKAY, 0, 1'b0, 8'h00);
        check_value("irq_cleared", 32'(irq), 32'd0);

        // bit0 falls (rising mode, ignored); bit1 falls (falling mode, not enabled)
        sw = 4'b1000;
        tick(6);
        check_value("irq_falling", 32'(irq), 32'd0);
        axi_read(32'h14, 32'h2, OKAY, 0);
        axi_read(32'h00, 32'h8, OKAY, 0);

        axi_read(32'h1C, 32'h0, SLVERR, 5);
        axi_write(32'h00, 32'hFF, SLVERR, 0, 1'b0, 8'h00);
        check_value("led_ro_write", 32'(led), 32'h33);
        axi_read(32'h04, 32'h33, OKAY, 0);
        axi_read(32'h18, 32'h1, OKAY, 0);

        axi_write(32'h04, 32'h77, OKAY, 0, 1'b1, 8'h00);
        check_value("led_before_rst", 32'(led), 32'h77);
        #2 rst_n = 1'b0;
        #1;
        check_value("rst_b_valid", 32'(bus.b_valid), 32'd0);
        check_value("rst_led_mid", 32'(led), 32'(OUT_RESET));
        check_value("rst_awready", 32'(bus.axi_awready), 32'd0);
        #2 rst_n = 1'b1;
        tick(1);
        check_value("b_valid_after_rst", 32'(bus.b_valid), 32'd0);
        tick(2);
        axi_read(32'h14, 32'h0, OKAY, 0);
        axi_read(32'h04, 32'(OUT_RESET), OKAY, 0);
        axi_read(32'h10, 32'h0, OKAY, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpio_axi_multi.md
# gpio_axi_multi

Parametrised AXI4-Lite GPIO peripheral; successor to the fixed 4-in/8-out GPIO slave. Provides a synchronised input port of configurable width, an output port with set/clear aliases, and per-bit edge-detect interrupts with a single combined interrupt line. Sits on the processor's AXI-Lite peripheral bus beside the other memory-mapped I/O slaves. Runs entirely on the rising edge of one clock.

## Interface
- IN_WIDTH, 4, input port width (1..32)
- OUT_WIDTH, 8, output port width (1..32)
- OUT_RESET, 0, reset value of led (OUT_WIDTH bits)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- axi_araddr  in  32  read address (byte)
- axi_arvalid / axi_arready  in / out  1  read address handshake
- axi_rdata  out  32  read data
- axi_rresp  out  2  read response: 00 OKAY, 10 SLVERR
- axi_rvalid / axi_rready  out / in  1  read data handshake
- axi_awaddr  in  32  write address (byte)
- axi_awvalid / axi_awready  in / out  1  write address handshake
- axi_wdata  in  32  write data
- axi_wvalid / axi_wready  in / out  1  write data handshake
- b_valid / b_ready  out / in  1  write response handshake
- b_response  out  2  write response: 00 OKAY, 10 SLVERR
- sw  in  IN_WIDTH  asynchronous external inputs
- led  out  OUT_WIDTH  registered outputs
- irq  out  1  level interrupt, registered

## Operation
- Decode on addr[4:2]; addr[1:0] and addr[31:5] ignored (aliases). Reads zero-extend to 32 bits; writes use low bits only; no byte strobes.
- 0x00 IN (RO): synchronised sw. 0x04 OUT (RW): led. 0x08 OUT_SET (WO): led |= wdata; reads 0. 0x0C OUT_CLR (WO): led &= ~wdata; reads 0. 0x10 IRQ_EN (RW, IN_WIDTH). 0x14 IRQ_STATUS (RW1C, IN_WIDTH). 0x18 IRQ_EDGE (RW, IN_WIDTH; 1 = rising, 0 = falling). 0x1C unmapped.
- Unmapped read: rdata 0, rresp SLVERR. Write to 0x00 or 0x1C: no state change, b_response SLVERR. All other accesses OKAY.
- sw passes a 2-flop synchroniser (sync). A third register (prev) holds last sync. Bit i edge = IRQ_EDGE[i] ? (sync & ~prev) : (~sync & prev); edge sets IRQ_STATUS[i] regardless of IRQ_EN.
- irq register = |(IRQ_STATUS & IRQ_EN), updated every cycle.
- Read FSM: R_IDLE (arready=1) -> on arvalid: capture address, go R_DATA (arready=0, rvalid=1, rdata/rresp registered) -> on rready: R_IDLE.
- Write FSM: W_IDLE (awready=1, wready=1). Address and data accepted independently, in either order or together; each ready drops for the channel once captured. When both held: perform write, b_valid=1, go W_RESP (both readies 0) -> on b_ready: W_IDLE.
- Read and write channels independent; a read of a register in the same cycle as its write returns the pre-write value.

## Timing
- Reset (rst_n low, asynchronously): arready, awready, wready, rvalid, b_valid, irq = 0; rdata = 0; rresp, b_response = 00; led = OUT_RESET; IRQ_EN, IRQ_STATUS, IRQ_EDGE = 0 (falling mode); sync, prev = 0. Readies assert at the first rising edge after rst_n rises.
- Read: arvalid&&arready at edge N -> rvalid=1 with data after edge N; rvalid, rdata held stable until rready sampled high; arready returns 1 after that edge. Max throughput one read per 2 cycles.
- Write: last of aw/w captured at edge N -> register updated and b_valid=1 after edge N+1; readies reassert after the edge sampling b_valid&&b_ready.
- Input: sw change -> IN readback reflects it after 2 edges; IRQ_STATUS bit set after 3 edges; irq after 4 edges.
- Same-edge RW1C clear and new edge on a bit: set wins.
- Changing IRQ_EDGE does not itself generate an edge event.
- rst_n asserted mid-transaction: transaction abandoned, no b_valid/rvalid issued afterwards.

## Test plan
- Reset release: led = OUT_RESET, all readies 1 after first edge; read 0x00 with sw=4'b1010 -> rdata 0x0000000A, rresp 00, rvalid one cycle after ar handshake.
- Write 0x04 = 0xFFFFFF5A (OUT_WIDTH=8) -> led = 0x5A, b_response 00; write 0x08 = 0x81 -> led 0xDB; write 0x0C = 0x0F -> led 0xD0.
- Write with wvalid 3 cycles before awvalid -> wready drops after data capture, led updates only after address captured, single b_valid.
- IRQ_EN=0x1, IRQ_EDGE=0x1, sw[0] 0->1 -> IRQ_STATUS=0x1 and irq=1 within 4 cycles; write 0x14 = 0x1 -> irq=0; falling edge ignored while IRQ_EDGE=1.
- Read 0x1C -> rdata 0, rresp 10; write 0x00 -> b_response 10, no state change; rready held low 5 cycles -> rvalid and rdata stable throughout.
- rst_n pulsed low during W_RESP with b_ready low -> b_valid drops immediately, led = OUT_RESET, IRQ_STATUS = 0.
